// File: rtl/music_pkg.sv
// Shared note encoding, pitch table and FSM state type for the note tone player.
package music_pkg;

  localparam int unsigned BASE_W = 20;
  localparam logic [3:0]  NOTE_REST_MIN = 4'd12;

  // Half-period in 50 MHz cycles of each note in octave 1 (C..B).
  localparam logic [BASE_W-1:0] BASE_HALF [0:11] = '{
    20'd764526, 20'd721501, 20'd681013, 20'd642839,
    20'd606796, 20'd572738, 20'd540541, 20'd510204,
    20'd481603, 20'd454545, 20'd429037, 20'd404924
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       reserved;
    logic [2:0] octave;
    logic [3:0] note;
  } fullnote_t;

  function automatic logic is_rest(input logic [3:0] idx);
    return idx >= NOTE_REST_MIN;
  endfunction

  function automatic logic [BASE_W-1:0] half_period(input logic [3:0] idx,
                                                    input logic [2:0] oct);
    logic [BASE_W-1:0] base;
    base = '0;
    if (!is_rest(idx)) base = BASE_HALF[idx];
    return base >> oct;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter producing a square wave; held cleared while disabled.
module tone_divider #(
  parameter int unsigned DIV_W = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] half,
  output logic             wave
);

  logic [DIV_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c = (cnt == half - DIV_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (wrap_c) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/note_tone_player.sv
// Plays one note at a time as a square wave for note_len ticks, then a silent gap.
// Optional NOTE_PWM_VOL_EN adds a 2-bit volume input gating the wave with PWM.
module note_tone_player
  import music_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 500_000,
  parameter int unsigned GAP_TICKS = 2,
  parameter int unsigned DIV_W     = 20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] fullnote,
  input  logic [7:0] note_len,
  input  logic       note_valid,
`ifdef NOTE_PWM_VOL_EN
  input  logic [1:0] volume,
`endif
  output logic       note_ready,
  output logic       speaker,
  output logic       playing
);

  localparam int unsigned     TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]      GAP_LEN   = 8'(GAP_TICKS);

  state_t            state;
  state_t            next_state;
  fullnote_t         fn_in;
  fullnote_t         note_q;
  logic [7:0]        remain;
  logic [TICK_W-1:0] tick_cnt;
  logic              start_c;
  logic              tick_wrap_c;
  logic              last_tick_c;
  logic              tone_en_c;
  logic              rest_next_c;
  logic              ready_next;
  logic              playing_next;
  logic [DIV_W-1:0]  half_c;
  logic              raw_wave;

  assign fn_in       = fullnote_t'(fullnote);
  assign start_c     = (state == IDLE) && note_valid && (note_len != 8'd0);
  assign tick_wrap_c = (tick_cnt == TICK_LAST);
  assign last_tick_c = tick_wrap_c && (remain == 8'd1);
  // Divider drops out on the final PLAY cycle so the exit edge leaves speaker low.
  assign tone_en_c   = (state == PLAY) && !is_rest(note_q.note) && !last_tick_c;
  assign half_c      = DIV_W'(half_period(note_q.note, note_q.octave));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_c) next_state = PLAY;
      PLAY:    if (last_tick_c) next_state = (GAP_TICKS > 0) ? GAP : IDLE;
      GAP:     if (last_tick_c) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    rest_next_c  = is_rest(note_q.note);
    ready_next   = 1'b0;
    playing_next = 1'b0;
    if (start_c) rest_next_c = is_rest(fn_in.note);
    ready_next   = (next_state == IDLE);
    playing_next = (next_state == PLAY) && !rest_next_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      note_ready <= 1'b1;
      playing    <= 1'b0;
    end else begin
      note_ready <= ready_next;
      playing    <= playing_next;
    end
  end

  // Tick and remaining-length counters; remain reloads with the gap length at PLAY exit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      note_q   <= '0;
      remain   <= '0;
      tick_cnt <= '0;
    end else if (state == IDLE) begin
      tick_cnt <= '0;
      if (start_c) begin
        note_q <= fn_in;
        remain <= note_len;
      end
    end else if (tick_wrap_c) begin
      tick_cnt <= '0;
      remain   <= ((state == PLAY) && (remain == 8'd1)) ? GAP_LEN : remain - 8'd1;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  tone_divider #(
    .DIV_W (DIV_W)
  ) u_tone_divider (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (tone_en_c),
    .half    (half_c),
    .wave    (raw_wave)
  );

`ifdef NOTE_PWM_VOL_EN
  logic [1:0] volume_q;
  logic [7:0] pwm_cnt;
  logic [8:0] pwm_limit_c;

  assign pwm_limit_c = (9'(volume_q) + 9'd1) << 6;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      volume_q <= '0;
      pwm_cnt  <= '0;
      speaker  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (start_c) volume_q <= volume;
      speaker <= raw_wave && tone_en_c && ({1'b0, pwm_cnt} < pwm_limit_c);
    end
  end
`else
  assign speaker = raw_wave;
`endif

endmodule
